imm_gen_pipe: RTL

- Parametrised successor of the combinational immediate extender. Covers all RV32/RV64 immediate formats, plus shift-amount and CSR zimm forms, at XLEN width.
- Output is registered behind a valid/ready skid buffer: one result per cycle, 1-cycle latency, no combinational ready path.
- Sits between the instruction register and the ALU source muxes. Lets the multi-cycle datapath stall the immediate independently of instruction fetch.

---
 rtl/imm_pkg.sv | 17 +
 rtl/imm_decode.sv | 41 ++++
 rtl/imm_gen_pipe.sv | 112 +++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared immediate-format encodings for the immediate generator.
package imm_pkg;

    localparam int unsigned IMM_SRC_W = 3;

    typedef logic [IMM_SRC_W-1:0] imm_src_t;

    localparam imm_src_t IMM_I     = 3'b000;
    localparam imm_src_t IMM_S     = 3'b001;
    localparam imm_src_t IMM_B     = 3'b010;
    localparam imm_src_t IMM_J     = 3'b011;
    localparam imm_src_t IMM_U     = 3'b100;
    localparam imm_src_t IMM_SHAMT = 3'b101;
    localparam imm_src_t IMM_ZIMM  = 3'b110;
    localparam imm_src_t IMM_ILL   = 3'b111;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: (instr, imm_src) -> (imm, err) at XLEN width.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_src_t        imm_src,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    // Every format fits a signed 32-bit value, so build that first and
    // sign-extend once to XLEN; SHAMT/ZIMM have a 0 MSB and thus zero-extend.
    logic [31:0] w_raw;
    logic        w_unused_opcode;

    assign w_unused_opcode = ^instr[6:0];

    // Select and assemble the immediate field for the requested format
    always_comb begin
        w_raw = '0;
        err   = 1'b0;
        case (imm_src)
            IMM_I:     w_raw = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     w_raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     w_raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            IMM_J:     w_raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0};
            IMM_U:     w_raw = {instr[31:12], 12'b0};
            IMM_SHAMT: w_raw = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
            IMM_ZIMM:  w_raw = {27'b0, instr[19:15]};
            IMM_ILL:   err   = 1'b1;
            default:   w_raw = '0;
        endcase
    end

    assign imm = XLEN'($signed(w_raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a valid/ready skid buffer.
// Optional IMM_ERR_CNT_EN adds a saturating counter of accepted illegal formats.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          instr,
    input  logic [2:0]           imm_src,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [XLEN-1:0]      imm_ext,
    output logic                 imm_err,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef IMM_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    if ((XLEN != 32 && XLEN != 64) || ERR_CNT_W < 1) begin : g_param_check
        $error("imm_gen_pipe: XLEN must be 32 or 64 and ERR_CNT_W at least 1");
    end

    logic [XLEN-1:0] w_imm;
    logic            w_err;
    logic            w_accept;
    logic            w_drain;
    logic            w_to_or;
    logic            w_sk_nxt;

    logic            r_in_ready;
    logic            r_or_valid;
    logic [XLEN-1:0] r_or_imm;
    logic            r_or_err;
    logic            r_sk_valid;
    logic [XLEN-1:0] r_sk_imm;
    logic            r_sk_err;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (instr),
        .imm_src (imm_src_t'(imm_src)),
        .imm     (w_imm),
        .err     (w_err)
    );

    assign w_accept = in_valid && r_in_ready;
    assign w_drain  = r_or_valid && out_ready;
    assign w_to_or  = w_accept && (!r_or_valid || w_drain);
    assign w_sk_nxt = (w_accept && !w_to_or) || (r_sk_valid && !w_drain);

    // Output register, skid entry and registered ready
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_ready <= 1'b0;
            r_or_valid <= 1'b0;
            r_or_imm   <= '0;
            r_or_err   <= 1'b0;
            r_sk_valid <= 1'b0;
            r_sk_imm   <= '0;
            r_sk_err   <= 1'b0;
        end else begin
            if (w_to_or) begin
                r_or_valid <= 1'b1;
                r_or_imm   <= w_imm;
                r_or_err   <= w_err;
            end else if (w_drain) begin
                if (r_sk_valid) begin
                    r_or_imm <= r_sk_imm;
                    r_or_err <= r_sk_err;
                end else begin
                    r_or_valid <= 1'b0;
                end
            end

            if (w_accept && !w_to_or) begin
                r_sk_valid <= 1'b1;
                r_sk_imm   <= w_imm;
                r_sk_err   <= w_err;
            end else if (w_drain) begin
                r_sk_valid <= 1'b0;
            end

            r_in_ready <= !w_sk_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_or_valid;
    assign imm_ext   = r_or_imm;
    assign imm_err   = r_or_err;

`ifdef IMM_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Count accepted illegal formats, holding at all-ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
        end else if (w_accept && imm_src_t'(imm_src) == IMM_ILL && r_err_cnt != '1) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign err_count = r_err_cnt;
`endif

endmodule
